// File: rtl/rpn_eval.sv
// Postfix (RPN) expression evaluator: one packed N_TOK-token job per handshake,
// one token per cycle on an internal operand stack, fixed N_TOK+2 cycle turnaround.
module rpn_eval #(
  parameter int N_TOK  = 19,
  parameter int DATA_W = 41,
  parameter int DEPTH  = (N_TOK + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [5*N_TOK-1:0]   in_rpn,
  output logic                 busy,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out,
  output logic                 err
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(N_TOK);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [5*N_TOK-1:0]   tok_q, tok_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_q, out_d;
  logic                 err_out_q, err_out_d;
  logic [DATA_W-1:0]    stack_q [DEPTH];
  logic [DATA_W-1:0]    stack_d [DEPTH];

  logic [4:0]           tok;
  logic [SP_W-1:0]      top_idx, nxt_idx;
  logic [DATA_W-1:0]    opa, opb, alu;
  logic                 div_zero;
  logic                 fin_err;

  // Tokens are consumed from the MSB end; the latched vector shifts left each cycle.
  assign tok     = tok_q[5*N_TOK-1 -: 5];
  assign top_idx = sp_q - SP_W'(1);
  assign nxt_idx = sp_q - SP_W'(2);

  always_comb begin
    opa      = '0;
    opb      = '0;
    if (sp_q >= SP_W'(2)) begin
      opa = stack_q[nxt_idx];
      opb = stack_q[top_idx];
    end
    div_zero = 1'b0;
    alu      = '0;
    unique case (tok[1:0])
      2'b00: alu = opa + opb;
      2'b01: alu = opa - opb;
      2'b10: alu = opa * opb;
      2'b11: begin
        if (opb == '0) div_zero = 1'b1;
        else           alu = DATA_W'($signed(opa) / $signed(opb));
      end
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    idx_d       = idx_q;
    sp_d        = sp_q;
    err_d       = err_q;
    busy_d      = busy_q;
    stack_d     = stack_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    err_out_d   = 1'b0;
    fin_err     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_EVAL;
          tok_d   = in_rpn;
          idx_d   = '0;
          sp_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_EVAL: begin
        if (!tok[4]) begin
          if (sp_q == SP_W'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            stack_d[sp_q] = {{(DATA_W-4){1'b0}}, tok[3:0]};
            sp_d          = sp_q + SP_W'(1);
          end
        end else begin
          if (sp_q < SP_W'(2)) begin
            err_d = 1'b1;
          end else begin
            stack_d[nxt_idx] = alu;
            sp_d             = top_idx;
            if (div_zero) err_d = 1'b1;
          end
        end
        tok_d = tok_q << 5;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_TOK - 1)) begin
          // Result is formed from this cycle's next-state so the last token counts.
          fin_err     = err_d | (sp_d != SP_W'(1));
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          err_out_d   = fin_err;
          out_d       = fin_err ? '0 : stack_d[0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tok_q       <= '0;
      idx_q       <= '0;
      sp_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      idx_q       <= idx_d;
      sp_q        <= sp_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_out_q   <= err_out_d;
    end
    stack_q <= stack_d;
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_out_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Directed self-checking bench for rpn_eval: arithmetic, malformed input,
// latency/busy timing, ignored strobes and reset behaviour.
module tb_rpn_eval;

  localparam int N_TOK  = 19;
  localparam int DATA_W = 41;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [5*N_TOK-1:0]  in_rpn;
  logic                busy;
  logic                out_valid;
  logic [DATA_W-1:0]   out;
  logic                err;

  int tests = 0;
  int fails = 0;

  logic [4:0] toks [N_TOK];

  rpn_eval #(.N_TOK(N_TOK), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_rpn    (in_rpn),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5*N_TOK-1:0] pack_toks();
    logic [5*N_TOK-1:0] r;
    r = '0;
    for (int i = 0; i < N_TOK; i++) r[5*(N_TOK-1-i) +: 5] = toks[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a job in the current cycle (T) and checks the full T+1..T+21 window.
  task automatic run_job(input string tag, input logic [DATA_W-1:0] exp_out, input logic exp_err);
    logic early, gap;
    in_valid = 1'b1;
    in_rpn   = pack_toks();
    @(negedge clk);
    in_valid = 1'b0;
    early = 1'b0;
    gap   = 1'b0;
    for (int k = 1; k < N_TOK + 1; k++) begin
      if (out_valid !== 1'b0) early = 1'b1;
      if (busy !== 1'b1) gap = 1'b1;
      @(negedge clk);
    end
    check({tag, ".early_ov"}, 64'(early), 64'd0);
    check({tag, ".busy_gap"}, 64'(gap), 64'd0);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".busy_last"}, 64'(busy), 64'd1);
    check({tag, ".out"}, 64'(out), 64'(exp_out));
    check({tag, ".err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    check({tag, ".ov_after"}, 64'(out_valid), 64'd0);
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    check({tag, ".out_after"}, 64'(out), 64'd0);
    check({tag, ".err_after"}, 64'(err), 64'd0);
  endtask

  initial begin
    int cnt, at;
    logic [DATA_W-1:0] val;
    logic [5*N_TOK-1:0] sum_rpn, mul_rpn, sub_rpn;

    rst = 1'b1;
    in_valid = 1'b0;
    in_rpn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out", 64'(out), 64'd0);
    check("rst.err", 64'(err), 64'd0);

    for (int i = 0; i < N_TOK; i++) toks[i] = (i < 10) ? 5'h01 : 5'h10;
    sum_rpn = pack_toks();
    run_job("sum", 41'd10, 1'b0);

    for (int i = 0; i < N_TOK; i++) toks[i] = (i < 10) ? 5'h0F : 5'h12;
    mul_rpn = pack_toks();
    run_job("mul", 41'd576650390625, 1'b0);

    toks[0] = 5'h00;
    for (int i = 1; i < N_TOK; i++) toks[i] = (i % 2 == 1) ? 5'h01 : 5'h11;
    sub_rpn = pack_toks();
    run_job("sub", 41'h1FF_FFFF_FFF7, 1'b0);

    toks[0] = 5'h00; toks[1] = 5'h07; toks[2] = 5'h11; toks[3] = 5'h02; toks[4] = 5'h13;
    for (int i = 5; i < N_TOK; i++) toks[i] = (i % 2 == 1) ? 5'h00 : 5'h10;
    run_job("div", 41'h1FF_FFFF_FFFD, 1'b0);

    toks[0] = 5'h05; toks[1] = 5'h00; toks[2] = 5'h13;
    for (int i = 3; i < N_TOK; i++) toks[i] = (i % 2 == 1) ? 5'h01 : 5'h10;
    run_job("div0", 41'd0, 1'b1);

    toks[0] = 5'h10; toks[1] = 5'h01;
    for (int i = 2; i < N_TOK; i++) toks[i] = (i % 2 == 0) ? 5'h01 : 5'h10;
    run_job("underflow", 41'd0, 1'b1);

    for (int i = 0; i < N_TOK; i++) toks[i] = 5'h03;
    run_job("overflow", 41'd0, 1'b1);

    // in_valid pulsed at T+5 while busy must be ignored
    in_valid = 1'b1;
    in_rpn   = sum_rpn;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    in_rpn   = mul_rpn;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0; at = -1; val = '0;
    for (int c = 6; c < 46; c++) begin
      if (out_valid === 1'b1) begin
        cnt++;
        at  = c;
        val = out;
      end
      @(negedge clk);
    end
    check("ignore.count", 64'(cnt), 64'd1);
    check("ignore.cycle", 64'(at), 64'd20);
    check("ignore.out", 64'(val), 64'd10);

    // rst at T+7 discards the job; new job at T+8 completes at T+28
    in_valid = 1'b1;
    in_rpn   = sum_rpn;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", 64'(busy), 64'd0);
    in_valid = 1'b1;
    in_rpn   = sub_rpn;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0; at = -1; val = '0;
    for (int c = 9; c < 40; c++) begin
      if (out_valid === 1'b1) begin
        cnt++;
        at  = c;
        val = out;
      end
      @(negedge clk);
    end
    check("rstmid.count", 64'(cnt), 64'd1);
    check("rstmid.cycle", 64'(at), 64'd28);
    check("rstmid.out", 64'(val), 64'(41'h1FF_FFFF_FFF7));

    // rst and in_valid together: the job is not accepted
    rst = 1'b1;
    in_valid = 1'b1;
    in_rpn = sum_rpn;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rstacc.busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid === 1'b1) cnt++;
      @(negedge clk);
    end
    check("rstacc.count", 64'(cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
